// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//
// Purpose
//   Parametrised pipeline stage register with a valid/ready handshake and a
//   2-entry skid buffer. It sits between fetch/decode/execute stages.
//   - It sustains full throughput of one beat per cycle.
//   - in_ready_o is a flop, so upstream never sees a combinational path
//     from out_ready_i.
//   - Beats always leave in the order they arrived.
//
// Storage
//   main_q drives out_data_o. skid_q catches the single beat that arrives
//   while the downstream stalls. Since ready is registered, this beat was
//   already committed to by the time the stall became visible.
//
// Parameters
//   DATA_W  payload width in bits
//   CNT_W   stall counter width (only meaningful with PIPE_STAGE_PERF_EN)
//
// Ports
//   clk_i        in   1       clock, rising edge
//   rst_i        in   1       asynchronous reset, active-low
//   flush_i      in   1       synchronous discard of all held beats
//   in_valid_i   in   1       upstream beat valid
//   in_ready_o   out  1       stage can accept (registered)
//   in_data_i    in   DATA_W  upstream payload
//   out_valid_o  out  1       downstream beat valid (registered)
//   out_ready_i  in   1       downstream accepts
//   out_data_o   out  DATA_W  downstream payload (registered)
//   occ_o        out  2       number of held beats: 0, 1 or 2
//   stall_cnt_o  out  CNT_W   saturating backpressure cycle count
//                             (present only with PIPE_STAGE_PERF_EN)
//
// Configuration macro
//   PIPE_STAGE_PERF_EN : when defined, adds stall_cnt_o and its counter.
//                        The counter is cleared only by reset, never by flush.
// -----------------------------------------------------------------------------
module pipe_skid_stage #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

    // Encoding equals occupancy, so occ_o is simply the state value.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;

    logic              in_fire;
    logic              out_fire;

    // Handshakes use only registered ready/valid, which keeps the
    // timing paths short.
    assign in_fire  = in_valid_i & in_ready_q;
    assign out_fire = out_valid_q & out_ready_i;

    // -------------------------------------------------------------------------
    // Next-state / datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush_i) begin
            // A flush wins over any handshake in the same cycle.
            // Beats accepted or presented in this cycle are simply lost.
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_data_i;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data_i;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new beat behind main.
                        state_d = ST_FULL;
                        skid_d  = in_data_i;
                    end else if (out_fire) begin
                        // main keeps its payload; out_valid drops instead.
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready_q is low here, so no new beat can arrive.
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    // -------------------------------------------------------------------------
    // State and storage registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // -------------------------------------------------------------------------
    // Occupancy
    // -------------------------------------------------------------------------
    always_comb begin
        occ_o = 2'd0;
        unique case (state_q)
            ST_EMPTY: occ_o = 2'd0;
            ST_ONE:   occ_o = 2'd1;
            ST_FULL:  occ_o = 2'd2;
            default:  occ_o = 2'd0;
        endcase
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = main_q;

`ifdef PIPE_STAGE_PERF_EN
    // -------------------------------------------------------------------------
    // Backpressure counter
    // -------------------------------------------------------------------------
    // It counts every cycle in which a beat is offered but not taken, and
    // stops at all-ones. Flush is deliberately ignored so that the statistic
    // survives pipeline redirects.
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_stage
// Self-checking bench for pipe_skid_stage.
// - The reference model is a FIFO queue of at most two beats plus the last
//   shown payload.
// - Inputs are driven on the falling clock edge.
// - Outputs are compared on the next falling edge, after the rising edge that
//   consumed those inputs.
// -----------------------------------------------------------------------------
module tb_pipe_skid_stage;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 2;   // small so saturation is reachable quickly

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic [1:0]        occ_o;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]  stall_cnt_o;
`endif

    pipe_skid_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .occ_o       (occ_o)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: beats held in arrival order, plus what out_data shows.
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] m_last;
    int                m_stall;
    localparam int     STALL_MAX = (1 << CNT_W) - 1;

    task automatic model_reset();
        mq.delete();
        m_last  = '0;
        m_stall = 0;
    endtask

    // Applies one cycle of stimulus, steps the model, and returns at the
    // next falling edge.
    task automatic drive_cycle(input bit v, input logic [DATA_W-1:0] d,
                               input bit r, input bit f);
        bit in_fire, out_fire;
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = r;
        flush_i     = f;
        in_fire  = v && (mq.size() < 2);
        out_fire = (mq.size() > 0) && r;
        if ((mq.size() > 0) && !r && (m_stall < STALL_MAX)) m_stall++;
        @(posedge clk_i);
        if (f) begin
            mq.delete();
            m_last = '0;
        end else begin
            if (out_fire) m_last = mq.pop_front();
            if (in_fire) mq.push_back(d);
            if (mq.size() > 0) m_last = mq[0];
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b0; flush_i = 0; in_valid_i = 0; in_data_i = '0; out_ready_i = 0;
        model_reset();
        repeat (2) @(negedge clk_i);
        n_tests++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
        n_tests++; if (out_data_o !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", out_data_o); end
        n_tests++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", in_ready_o); end
        n_tests++; if (occ_o !== 2'd0) begin n_fail++; $display("FAIL reset_occ got=%0d exp=0", occ_o); end
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 8; i++) begin
            drive_cycle(1'b1, 64'(i), 1'b1, 1'b0);
            n_tests++; if (out_valid_o !== 1'b1 || out_data_o !== 64'(i)) begin
                n_fail++; $display("FAIL stream_out beat=%0d got v=%b d=%h exp v=1 d=%h", i, out_valid_o, out_data_o, 64'(i)); end
            n_tests++; if (in_ready_o !== 1'b1 || occ_o > 2'd1) begin
                n_fail++; $display("FAIL stream_flow beat=%0d got rdy=%b occ=%0d exp rdy=1 occ<=1", i, in_ready_o, occ_o); end
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        n_tests++; if (out_valid_o !== 1'b0 || out_data_o !== 64'h8) begin
            n_fail++; $display("FAIL stream_drain got v=%b d=%h exp v=0 d=8", out_valid_o, out_data_o); end
    endtask

    task automatic test_backpressure();
        drive_cycle(1'b1, 64'hA, 1'b0, 1'b0);
        n_tests++; if (occ_o !== 2'd1 || out_data_o !== 64'hA || in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_first got occ=%0d d=%h rdy=%b exp occ=1 d=a rdy=1", occ_o, out_data_o, in_ready_o); end
        drive_cycle(1'b1, 64'hB, 1'b0, 1'b0);
        n_tests++; if (occ_o !== 2'd2 || out_data_o !== 64'hA || in_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_full got occ=%0d d=%h rdy=%b exp occ=2 d=a rdy=0", occ_o, out_data_o, in_ready_o); end
        // A beat offered while not ready must not be taken.
        drive_cycle(1'b1, 64'hEE, 1'b0, 1'b0);
        n_tests++; if (occ_o !== 2'd2 || out_data_o !== 64'hA || out_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_hold got occ=%0d d=%h v=%b exp occ=2 d=a v=1", occ_o, out_data_o, out_valid_o); end
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        n_tests++; if (out_valid_o !== 1'b1 || out_data_o !== 64'hB || occ_o !== 2'd1 || in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_release got v=%b d=%h occ=%0d rdy=%b exp v=1 d=b occ=1 rdy=1", out_valid_o, out_data_o, occ_o, in_ready_o); end
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        n_tests++; if (out_valid_o !== 1'b0 || occ_o !== 2'd0) begin
            n_fail++; $display("FAIL bp_empty got v=%b occ=%0d exp v=0 occ=0", out_valid_o, occ_o); end
    endtask

    task automatic test_flush_full();
        drive_cycle(1'b1, 64'hA, 1'b0, 1'b0);
        drive_cycle(1'b1, 64'hB, 1'b0, 1'b0);
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        n_tests++; if (out_valid_o !== 1'b0 || occ_o !== 2'd0 || out_data_o !== '0 || in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_full got v=%b occ=%0d d=%h rdy=%b exp v=0 occ=0 d=0 rdy=1", out_valid_o, occ_o, out_data_o, in_ready_o); end
        drive_cycle(1'b1, 64'hC, 1'b1, 1'b0);
        n_tests++; if (out_valid_o !== 1'b1 || out_data_o !== 64'hC) begin
            n_fail++; $display("FAIL flush_next got v=%b d=%h exp v=1 d=c", out_valid_o, out_data_o); end
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        n_tests++; if (out_valid_o !== 1'b0 || occ_o !== 2'd0) begin
            n_fail++; $display("FAIL flush_next_drain got v=%b occ=%0d exp v=0 occ=0", out_valid_o, occ_o); end
    endtask

    task automatic test_flush_simultaneous();
        drive_cycle(1'b1, 64'hD, 1'b1, 1'b1);
        n_tests++; if (out_valid_o !== 1'b0 || occ_o !== 2'd0 || out_data_o !== '0) begin
            n_fail++; $display("FAIL flush_sim got v=%b occ=%0d d=%h exp v=0 occ=0 d=0", out_valid_o, occ_o, out_data_o); end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 64'(32'h100 + i), 1'b0, 1'b1);
            n_tests++; if (in_ready_o !== 1'b1 || occ_o !== 2'd0 || out_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL flush_held cyc=%0d got rdy=%b occ=%0d v=%b exp rdy=1 occ=0 v=0", i, in_ready_o, occ_o, out_valid_o); end
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        n_tests++; if (out_valid_o !== 1'b0 || occ_o !== 2'd0) begin
            n_fail++; $display("FAIL flush_after got v=%b occ=%0d exp v=0 occ=0", out_valid_o, occ_o); end
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        int base;
        int exp_cnt;
        base = m_stall;
        drive_cycle(1'b1, 64'h7, 1'b0, 1'b0);
        repeat (5) drive_cycle(1'b0, '0, 1'b0, 1'b0);
        exp_cnt = (base + 5 > STALL_MAX) ? STALL_MAX : base + 5;
        n_tests++; if (int'(stall_cnt_o) != exp_cnt) begin
            n_fail++; $display("FAIL perf_stall got=%0d exp=%0d", stall_cnt_o, exp_cnt); end
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
        n_tests++; if (int'(stall_cnt_o) != exp_cnt) begin
            n_fail++; $display("FAIL perf_flush got=%0d exp=%0d", stall_cnt_o, exp_cnt); end
    endtask
`endif

    task automatic test_async_reset();
        in_valid_i = 0; out_ready_i = 0; flush_i = 0;
        drive_cycle(1'b1, 64'hA, 1'b0, 1'b0);
        drive_cycle(1'b1, 64'hB, 1'b0, 1'b0);
        n_tests++; if (occ_o !== 2'd2) begin n_fail++; $display("FAIL areset_pre got occ=%0d exp=2", occ_o); end
        in_valid_i = 0;
        #2 rst_i = 1'b0;
        #1;
        n_tests++; if (out_valid_o !== 1'b0 || out_data_o !== '0 || in_ready_o !== 1'b1 || occ_o !== 2'd0) begin
            n_fail++; $display("FAIL areset_now got v=%b d=%h rdy=%b occ=%0d exp v=0 d=0 rdy=1 occ=0", out_valid_o, out_data_o, in_ready_o, occ_o); end
`ifdef PIPE_STAGE_PERF_EN
        n_tests++; if (stall_cnt_o !== '0) begin n_fail++; $display("FAIL areset_cnt got=%0d exp=0", stall_cnt_o); end
`endif
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive_cycle($urandom_range(0, 9) < 7, {$urandom, $urandom},
                        $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0);
            n_tests++; if (out_valid_o !== (mq.size() > 0) || out_data_o !== m_last) begin
                n_fail++; $display("FAIL rand_out cyc=%0d got v=%b d=%h exp v=%b d=%h", c, out_valid_o, out_data_o, mq.size() > 0, m_last); end
            n_tests++; if (in_ready_o !== (mq.size() < 2) || occ_o !== 2'(mq.size())) begin
                n_fail++; $display("FAIL rand_flow cyc=%0d got rdy=%b occ=%0d exp rdy=%b occ=%0d", c, in_ready_o, occ_o, mq.size() < 2, mq.size()); end
`ifdef PIPE_STAGE_PERF_EN
            n_tests++; if (int'(stall_cnt_o) != m_stall) begin
                n_fail++; $display("FAIL rand_stall cyc=%0d got=%0d exp=%0d", c, stall_cnt_o, m_stall); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_flush_simultaneous();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
